// File: rtl/softmax_pkg.sv
// Shared types and default sizing for the softmax pipeline latency tracker.
package softmax_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int unsigned DEF_LATENCY = 23;
  localparam int unsigned DEF_VEC_LEN = 10;

  // Index width for a vector of n elements, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/valid_delay_line.sv
// Clock-enabled shift register carrying the per-element valid bit through
// a fixed number of pipeline stages.
module valid_delay_line
  import softmax_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_LATENCY
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] sr_q;
  logic [DEPTH-1:0] sr_d;

  generate
    if (DEPTH == 1) begin : g_single
      assign sr_d = d;
    end else begin : g_shift
      assign sr_d = {sr_q[DEPTH-2:0], d};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q <= '0;
    end else if (enable) begin
      sr_q <= sr_d;
    end
  end

  assign q = sr_q[DEPTH-1];

endmodule

// File: rtl/pipe_latency_tracker.sv
// Tracks elements through a fixed-latency softmax pipeline: exit valid,
// per-vector index, occupancy and flush/drain sequencing.
// Optional LAT_TRACK_PERF_EN adds a saturating busy-cycle counter.
module pipe_latency_tracker
  import softmax_pkg::*;
#(
  parameter  int unsigned LATENCY = DEF_LATENCY,
  parameter  int unsigned VEC_LEN = DEF_VEC_LEN,
  localparam int unsigned IDX_W   = idx_width(VEC_LEN),
  localparam int unsigned INFL_W  = $clog2(LATENCY + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              in_valid,
  input  logic              flush,
  output logic              out_valid,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic              vec_done,
  output logic [INFL_W-1:0] inflight,
  output logic              busy,
`ifdef LAT_TRACK_PERF_EN
  output logic [31:0]       perf_cycles,
`endif
  output logic              drain_done
);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  out_idx_q, out_idx_d;
  logic [INFL_W-1:0] inflight_q, inflight_d;
  logic              vec_done_q;
  logic              drain_done_q, drain_done_d;

  logic dl_q;
  logic accept_c;
  logic exit_c;
  logic last_c;
  logic go_drain_c;

  assign accept_c   = enable & in_valid & (state_q != DRAIN) & ~flush;
  assign exit_c     = enable & dl_q;
  assign last_c     = exit_c & (out_idx_q == IDX_W'(VEC_LEN - 1));
  assign go_drain_c = flush & (state_q != DRAIN);

  valid_delay_line #(
    .DEPTH (LATENCY)
  ) u_dl (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .d      (accept_c),
    .q      (dl_q)
  );

  // Occupancy: entries minus exits; both in one cycle cancel out.
  always_comb begin
    inflight_d = inflight_q;
    if (accept_c && !exit_c) begin
      inflight_d = inflight_q + INFL_W'(1);
    end else if (exit_c && !accept_c) begin
      inflight_d = inflight_q - INFL_W'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    drain_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (go_drain_c) begin
          state_d = DRAIN;
        end else if (accept_c) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (go_drain_c) begin
          state_d = DRAIN;
        end else if (inflight_d == '0) begin
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (inflight_q == '0) begin
          state_d      = IDLE;
          drain_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Index restarts at 0 as soon as a drain has emptied the pipeline.
  always_comb begin
    out_idx_d = out_idx_q;
    if ((state_q == DRAIN || go_drain_c) && inflight_d == '0) begin
      out_idx_d = '0;
    end else if (exit_c) begin
      out_idx_d = (out_idx_q == IDX_W'(VEC_LEN - 1)) ? '0 : out_idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      out_idx_q    <= '0;
      inflight_q   <= '0;
      vec_done_q   <= 1'b0;
      drain_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_idx_q    <= out_idx_d;
      inflight_q   <= inflight_d;
      vec_done_q   <= last_c;
      drain_done_q <= drain_done_d;
    end
  end

`ifdef LAT_TRACK_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_q <= '0;
    end else if (busy && (perf_q != '1)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles = perf_q;
`endif

  assign out_valid  = exit_c;
  assign out_idx    = out_idx_q;
  assign out_last   = last_c;
  assign vec_done   = vec_done_q;
  assign inflight   = inflight_q;
  assign busy       = (inflight_q != '0);
  assign drain_done = drain_done_q;

endmodule
